// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared playfield geometry, paddle defaults, the paddle FSM state encoding and
// clamped step helpers. The ball state machine uses the same playfield
// constants, so changes here move both the ball and the paddles.
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam int Y_MIN         = 5;
   localparam int Y_MAX         = 476;
   localparam int PADDLE_HALF   = 45;

   localparam int POS_W         = 10;
   localparam int POS_MIN_DEF   = Y_MIN + PADDLE_HALF;   // 50
   localparam int POS_MAX_DEF   = Y_MAX - PADDLE_HALF;   // 431
   localparam int POS_INIT_DEF  = 245;                   // ball serve row

   // One-hot so each state bit can be probed directly.
   typedef enum logic [2:0] {
      PAD_IDLE = 3'b001,
      PAD_UP   = 3'b010,
      PAD_DOWN = 3'b100
   } paddle_state_e;

   // Steps use 11-bit operands so pos +/- speed can never wrap before the
   // clamp is applied.
   function automatic logic [10:0] move_up(input logic [10:0] pos,
                                           input logic [10:0] spd,
                                           input logic [10:0] lo);
      return (pos < lo + spd) ? lo : pos - spd;
   endfunction

   function automatic logic [10:0] move_down(input logic [10:0] pos,
                                             input logic [10:0] spd,
                                             input logic [10:0] hi);
      return (pos + spd > hi) ? hi : pos + spd;
   endfunction

endpackage

// File: rtl/pong_paddle_axis.sv
// ---------------------------------------------------------------------------
// pong_paddle_axis
// One paddle: 2-FF synchroniser and debouncer per button, IDLE/UP/DOWN
// movement FSM with hold-to-accelerate, and clamping to the playfield.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   up, down     raw asynchronous buttons, active-high
//   tick         movement strobe (already gated by freeze/recenter upstream)
//   freeze       hold position, force IDLE, reset speed/hold
//   recenter     return to POS_INIT, force IDLE, reset speed/hold
//   position     registered paddle centre row
//   state        current FSM state (drives the moving flag and debug probes)
// ---------------------------------------------------------------------------
module pong_paddle_axis
   import pong_pkg::*;
#(
   parameter int POS_INIT    = POS_INIT_DEF,
   parameter int POS_MIN     = POS_MIN_DEF,
   parameter int POS_MAX     = POS_MAX_DEF,
   parameter int STEP_MIN    = 2,
   parameter int STEP_MAX    = 8,
   parameter int ACCEL_TICKS = 8,
   parameter int DB_CYCLES   = 250000,
   parameter int DB_W        = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up,
   input  logic             down,
   input  logic             tick,
   input  logic             freeze,
   input  logic             recenter,
   output logic [POS_W-1:0] position,
   output paddle_state_e    state
);

   localparam int SPD_W  = $clog2(STEP_MAX + 1);
   localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

   localparam logic [SPD_W-1:0]  SPD_MIN   = SPD_W'(STEP_MIN);
   localparam logic [SPD_W-1:0]  SPD_MAX   = SPD_W'(STEP_MAX);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_TICKS);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

   // Bit 0 = up, bit 1 = down throughout the input path.
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      db;
   logic [DB_W-1:0] db_cnt [2];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= {down, up};
         sync2 <= sync1;
         // Accept a change only after DB_CYCLES consecutive disagreeing
         // cycles; the counter reaching DB_CYCLES-1 means this is the last.
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db[i]     <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   logic up_only;
   logic down_only;
   assign up_only   = db[0] & ~db[1];
   assign down_only = db[1] & ~db[0];

   paddle_state_e     state_q, state_d;
   logic [SPD_W-1:0]  speed_q, speed_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [POS_W-1:0]  pos_q, pos_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PAD_IDLE;
         speed_q <= SPD_MIN;
         hold_q  <= '0;
         pos_q   <= POS_W'(POS_INIT);
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         hold_q  <= hold_d;
         pos_q   <= pos_d;
      end
   end

   logic [10:0]       pos_w;
   logic [10:0]       spd_w;
   logic [HOLD_W-1:0] hold_inc;
   logic              moved;

   assign pos_w    = {1'b0, pos_q};
   assign spd_w    = 11'(speed_q);
   assign hold_inc = hold_q + 1'b1;

   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      hold_d  = hold_q;
      pos_d   = pos_q;
      moved   = 1'b0;

      if (recenter) begin
         state_d = PAD_IDLE;
         speed_d = SPD_MIN;
         hold_d  = '0;
         pos_d   = POS_W'(POS_INIT);
      end else if (freeze) begin
         state_d = PAD_IDLE;
         speed_d = SPD_MIN;
         hold_d  = '0;
      end else if (tick) begin
         unique case (state_q)
            PAD_IDLE: begin
               // Entry tick only loads the speed; the first move is next tick.
               if (up_only) begin
                  state_d = PAD_UP;
                  speed_d = SPD_MIN;
                  hold_d  = '0;
               end else if (down_only) begin
                  state_d = PAD_DOWN;
                  speed_d = SPD_MIN;
                  hold_d  = '0;
               end
            end
            PAD_UP: begin
               if (up_only) begin
                  pos_d = POS_W'(move_up(pos_w, spd_w, 11'(POS_MIN)));
                  moved = 1'b1;
               end else begin
                  state_d = PAD_IDLE;
               end
            end
            PAD_DOWN: begin
               if (down_only) begin
                  pos_d = POS_W'(move_down(pos_w, spd_w, 11'(POS_MAX)));
                  moved = 1'b1;
               end else begin
                  state_d = PAD_IDLE;
               end
            end
            default: state_d = PAD_IDLE;
         endcase

         if (moved) begin
            if (hold_inc == HOLD_LAST) begin
               hold_d  = '0;
               speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 1'b1;
            end else begin
               hold_d = hold_inc;
            end
         end
      end
   end

   assign position = pos_q;
   assign state    = state_q;

endmodule

// File: rtl/pong_paddle_ctrl.sv
// ---------------------------------------------------------------------------
// pong_paddle_ctrl
// Two independent paddle axes driven from raw push-buttons. This level only
// resolves the control priority (recenter > freeze > tick) before fanning it
// out to both axes; reset is handled inside each axis and wins over all.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   tick                    one-cycle movement strobe
//   p1_up/p1_down/p2_up/p2_down  raw asynchronous buttons, active-high
//   freeze                  level: hold both paddles in place
//   recenter                pulse: return both paddles to POS_INIT
//   p1_position/p2_position paddle centre rows (0 = top)
//   p1_moving/p2_moving     high while that paddle's FSM is UP or DOWN
// ---------------------------------------------------------------------------
module pong_paddle_ctrl
   import pong_pkg::*;
#(
   parameter int POS_INIT    = POS_INIT_DEF,
   parameter int POS_MIN     = POS_MIN_DEF,
   parameter int POS_MAX     = POS_MAX_DEF,
   parameter int STEP_MIN    = 2,
   parameter int STEP_MAX    = 8,
   parameter int ACCEL_TICKS = 8,
   parameter int DB_CYCLES   = 250000,
   parameter int DB_W        = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             p1_up,
   input  logic             p1_down,
   input  logic             p2_up,
   input  logic             p2_down,
   input  logic             freeze,
   input  logic             recenter,
   output logic [POS_W-1:0] p1_position,
   output logic [POS_W-1:0] p2_position,
   output logic             p1_moving,
   output logic             p2_moving
);

   logic recenter_g;
   logic freeze_g;
   logic tick_g;

   assign recenter_g = recenter;
   assign freeze_g   = freeze & ~recenter;
   assign tick_g     = tick & ~freeze & ~recenter;

   paddle_state_e p1_state;
   paddle_state_e p2_state;

   pong_paddle_axis #(
      .POS_INIT(POS_INIT), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
      .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX), .ACCEL_TICKS(ACCEL_TICKS),
      .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)
   ) u_p1 (
      .clk(clk), .reset(reset), .up(p1_up), .down(p1_down),
      .tick(tick_g), .freeze(freeze_g), .recenter(recenter_g),
      .position(p1_position), .state(p1_state)
   );

   pong_paddle_axis #(
      .POS_INIT(POS_INIT), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX),
      .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX), .ACCEL_TICKS(ACCEL_TICKS),
      .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)
   ) u_p2 (
      .clk(clk), .reset(reset), .up(p2_up), .down(p2_down),
      .tick(tick_g), .freeze(freeze_g), .recenter(recenter_g),
      .position(p2_position), .state(p2_state)
   );

   assign p1_moving = (p1_state != PAD_IDLE);
   assign p2_moving = (p2_state != PAD_IDLE);

endmodule
